multicycle_seq: RTL and testbench

//  Multi-cycle control sequencer for the RV32 core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_seq.sv | 96 +++++++++
 tb/tb_multicycle_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// Multi-cycle control sequencer for an RV32 core: FETCH/DECODE/EXEC/MEM/WB stepping,
// imem/dmem handshakes, write strobes, retired counter, bus timeout and halt control.
module multicycle_seq #(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   input  logic        lw_en,
   input  logic        sw_en,
   input  logic        wr_en,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        rf_we,
   output logic        pc_we,
   input  logic        halt_req,
   output logic        halted,
   output logic        fault,
   output logic [31:0] instret
);

   // A zero TIMEOUT still needs a legal one-bit counter; the compare is gated off.
   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WCW-1:0] LAST_WAIT = WCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;

   state_t           state_reg, state_next;
   logic [WCW-1:0]   wait_cnt_reg, wait_cnt_next;
   logic [31:0]      ir_reg;
   logic [31:0]      instret_reg;
   logic             last_wait;

   assign last_wait = (TIMEOUT != 0) && (wait_cnt_reg == LAST_WAIT);

   // wait_cnt is zero outside FETCH/MEM, so it is already clear on entry to either.
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = '0;
      case (state_reg)
         S_BOOT:   state_next = S_FETCH;
         S_FETCH: begin
            if (imem_ack)       state_next = S_DECODE;
            else if (last_wait) state_next = S_FAULT;
            else                wait_cnt_next = wait_cnt_reg + 1'b1;
         end
         S_DECODE: state_next = (ir_reg[1:0] != 2'b11) ? S_FAULT : S_EXEC;
         S_EXEC: begin
            if (lw_en && sw_en)      state_next = S_FAULT;
            else if (lw_en || sw_en) state_next = S_MEM;
            else                     state_next = S_WB;
         end
         S_MEM: begin
            if (dmem_ack)       state_next = S_WB;
            else if (last_wait) state_next = S_FAULT;
            else                wait_cnt_next = wait_cnt_reg + 1'b1;
         end
         S_WB:     state_next = halt_req ? S_HALT : S_FETCH;
         S_HALT:   if (!halt_req) state_next = S_FETCH;
         S_FAULT:  state_next = S_FAULT;
         default:  state_next = S_FAULT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_BOOT;
         wait_cnt_reg <= '0;
         ir_reg       <= NOP_INSTR;
         instret_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         if (state_reg == S_FETCH && imem_ack) ir_reg <= imem_rdata;
         if (state_reg == S_WB) instret_reg <= instret_reg + 32'd1;
      end
   end

   assign imem_req = (state_reg == S_FETCH);
   assign dmem_req = (state_reg == S_MEM);
   assign dmem_we  = (state_reg == S_MEM) && sw_en;
   assign rf_we    = (state_reg == S_WB) && wr_en && !sw_en;
   assign pc_we    = (state_reg == S_WB);
   assign halted   = (state_reg == S_HALT);
   assign fault    = (state_reg == S_FAULT);
   assign ir       = ir_reg;
   assign instret  = instret_reg;

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: directed cases then randomized instruction streams,
// each instruction's expected per-cycle strobe trace derived from its class and handshake delays.
module tb_multicycle_seq;

   localparam int TO = 8;

   localparam logic [6:0] O_IMEM  = 7'b1000000;
   localparam logic [6:0] O_DMEM  = 7'b0100000;
   localparam logic [6:0] O_DWE   = 7'b0010000;
   localparam logic [6:0] O_PC    = 7'b0000100;
   localparam logic [6:0] O_RF    = 7'b0001000;
   localparam logic [6:0] O_HALT  = 7'b0000010;
   localparam logic [6:0] O_FAULT = 7'b0000001;

   logic        clk, rst;
   logic        imem_req, imem_ack;
   logic [31:0] imem_rdata, ir;
   logic        lw_en, sw_en, wr_en;
   logic        dmem_req, dmem_we, dmem_ack;
   logic        rf_we, pc_we, halt_req, halted, fault;
   logic [31:0] instret;
   logic        force_conflict;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_instret;

   multicycle_seq #(.TIMEOUT(TO), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
      .lw_en(lw_en), .sw_en(sw_en), .wr_en(wr_en),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .pc_we(pc_we),
      .halt_req(halt_req), .halted(halted), .fault(fault), .instret(instret)
   );

   // Stand-in for the core's instruction decoder, driven from ir.
   assign lw_en = (ir[6:0] == 7'h03) || force_conflict;
   assign sw_en = (ir[6:0] == 7'h23) || force_conflict;
   assign wr_en = !((ir[6:0] == 7'h23) || (ir[6:0] == 7'h63));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One clock cycle: compare the strobe vector mid-cycle, then advance past the next edge.
   task automatic cyc(input string tag, input logic [6:0] exp_out);
      @(negedge clk);
      chk(tag, {25'd0, imem_req, dmem_req, dmem_we, rf_we, pc_we, halted, fault},
               {25'd0, exp_out});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; halt_req = 1'b0; force_conflict = 1'b0;
      imem_rdata = 32'hdead_beef;
      @(posedge clk);
      #1;
      repeat (2) cyc("reset_outs", 7'd0);
      chk("reset_ir", ir, 32'h0000_0013);
      chk("reset_instret", instret, 32'd0);
      rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
      exp_instret = 32'd0;
      cyc("boot_outs", 7'd0);
   endtask

   task automatic fault_hold();
      imem_ack = 1'b0; dmem_ack = 1'b0;
      for (int k = 0; k < 20; k++) begin
         imem_ack = 1'($urandom); dmem_ack = 1'($urandom); halt_req = 1'($urandom);
         cyc("fault_hold", O_FAULT);
      end
      chk("fault_instret", instret, exp_instret);
   endtask

   // fd/dd: index of the req cycle carrying the ack; >= TO means no ack at all.
   task automatic run_instr(input logic [31:0] instr, input int fd, input int dd,
                            input bit hreq, input int hcyc, output bit faulted);
      bit is_lw, is_sw, is_wr;
      is_lw = (instr[6:0] == 7'h03) || force_conflict;
      is_sw = (instr[6:0] == 7'h23) || force_conflict;
      is_wr = !((instr[6:0] == 7'h23) || (instr[6:0] == 7'h63));
      faulted = 1'b0;
      $display("INFO instr=%h fd=%0d dd=%0d halt=%0d", instr, fd, dd, hreq);

      for (int k = 0; k < TO; k++) begin
         imem_ack   = (k == fd);
         imem_rdata = (k == fd) ? instr : $urandom;
         dmem_ack   = 1'($urandom);
         halt_req   = 1'($urandom);
         cyc("fetch", O_IMEM);
         if (k == fd) break;
      end
      if (fd >= TO) begin
         faulted = 1'b1; fault_hold(); return;
      end
      chk("ir_latched", ir, instr);

      imem_ack = 1'($urandom); imem_rdata = $urandom; dmem_ack = 1'($urandom);
      cyc("decode", 7'd0);
      if (instr[1:0] != 2'b11) begin
         faulted = 1'b1; fault_hold(); return;
      end
      cyc("exec", 7'd0);
      if (is_lw && is_sw) begin
         faulted = 1'b1; fault_hold(); return;
      end

      if (is_lw || is_sw) begin
         for (int k = 0; k < TO; k++) begin
            dmem_ack = (k == dd);
            imem_ack = 1'($urandom);
            cyc(is_sw ? "mem_store" : "mem_load", is_sw ? (O_DMEM | O_DWE) : O_DMEM);
            if (k == dd) break;
         end
         if (dd >= TO) begin
            faulted = 1'b1; fault_hold(); return;
         end
         chk("ir_stable", ir, instr);
      end

      halt_req = hreq; imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
      cyc("wb", O_PC | ((is_wr && !is_sw) ? O_RF : 7'd0));
      exp_instret = exp_instret + 32'd1;
      chk("instret", instret, exp_instret);

      if (hreq) begin
         for (int k = 0; k < hcyc; k++) cyc("halt", O_HALT);
         halt_req = 1'b0;
         cyc("halt_exit", O_HALT);
      end
      halt_req = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  op;
      r = $urandom;
      case ($urandom_range(0, 4))
         0:       op = 7'h13;
         1:       op = 7'h33;
         2:       op = 7'h03;
         3:       op = 7'h23;
         default: op = 7'h63;
      endcase
      return {r[31:7], op};
   endfunction

   initial begin
      bit f;
      exp_instret = 32'd0;
      do_reset();

      run_instr(32'h0050_0093, 0, 0, 1'b0, 0, f);       // addi, 4 cycles
      run_instr(32'h0000_2083, 0, 2, 1'b0, 0, f);       // lw, dmem_req 3 cycles
      run_instr(32'h0010_2023, 0, 0, 1'b0, 0, f);       // sw, immediate ack
      run_instr(32'h0050_0093, 2, 0, 1'b1, 3, f);       // halt after WB
      run_instr(32'h0000_2083, TO - 1, TO - 1, 1'b0, 0, f); // acks on the last allowed cycle
      chk("late_ack_no_fault", {31'd0, fault}, 32'd0);
      run_instr(32'h0050_0093, TO, 0, 1'b0, 0, f);      // fetch timeout
      chk("fetch_timeout_flag", {31'd0, f}, 32'd1);
      do_reset();

      run_instr(32'h0000_0000, 0, 0, 1'b0, 0, f);       // illegal encoding
      do_reset();
      run_instr(32'h0000_2083, 1, TO, 1'b0, 0, f);      // dmem timeout
      do_reset();
      force_conflict = 1'b1;
      run_instr(32'h0050_0093, 0, 0, 1'b0, 0, f);       // lw/sw decode conflict
      do_reset();

      imem_ack = 1'b0;
      repeat (3) cyc("fetch_pending", O_IMEM);
      do_reset();                                       // abandon an open fetch

      for (int n = 0; n < 300; n++) begin
         int  fd, dd, hc;
         bit  hr;
         fd = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, TO - 1);
         dd = ($urandom_range(0, 29) == 0) ? TO : $urandom_range(0, TO - 1);
         hr = ($urandom_range(0, 7) == 0);
         hc = $urandom_range(0, 4);
         run_instr(rand_instr(), fd, dd, hr, hc, f);
         if (f) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
